// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// The result is computed at accept time and committed to HI/LO when the busy countdown expires.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  state_e      state;
  logic [31:0] cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  logic        accept;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] b_mag_safe;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] mq;
  logic [31:0] mr;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_wr;

  assign accept = start & ~cancel & (state == StIdle);

  assign prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
  assign prod_u = {32'd0, srcA} * {32'd0, srcB};

  // Signed division via magnitudes; a zero divisor is replaced so the datapath never goes X,
  // and its result is simply never committed.
  assign a_mag      = srcA[31] ? (~srcA + 32'd1) : srcA;
  assign b_mag      = srcB[31] ? (~srcB + 32'd1) : srcB;
  assign b_safe     = (srcB == 32'd0) ? 32'd1 : srcB;
  assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign uq         = srcA / b_safe;
  assign ur         = srcA % b_safe;
  assign mq         = a_mag / b_mag_safe;
  assign mr         = a_mag % b_mag_safe;
  assign sq         = (srcA[31] ^ srcB[31]) ? (~mq + 32'd1) : mq;
  assign sr         = srcA[31] ? (~mr + 32'd1) : mr;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    case (op)
      OpMult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      OpMultu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      OpDiv: begin
        res_hi = sr;
        res_lo = sq;
        res_wr = (srcB != 32'd0);
      end
      OpDivu: begin
        res_hi = ur;
        res_lo = uq;
        res_wr = (srcB != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      cnt     <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (accept) begin
            case (op)
              OpMult, OpMultu: begin
                state   <= StBusy;
                busy    <= 1'b1;
                cnt     <= 32'(MULT_CYCLES);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
              end
              OpDiv, OpDivu: begin
                state   <= StBusy;
                busy    <= 1'b1;
                cnt     <= 32'(DIV_CYCLES);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
              end
              OpMthi: hi <= srcA;
              OpMtlo: lo <= srcA;
              default: ;
            endcase
          end
        end
        StBusy: begin
          if (cnt == 32'd1) begin
            state <= StIdle;
            busy  <= 1'b0;
            cnt   <= 32'd0;
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: timing, arithmetic corner cases, cancel and reset.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  e_mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srcA  (srcA),
    .srcB  (srcB),
    .cancel(cancel),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one cycle of start and returns at the following negedge.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    start  = 1'b1;
    op     = o;
    srcA   = a;
    srcB   = b;
    cancel = c;
    @(negedge clk);
    start  = 1'b0;
    op     = 3'd0;
    cancel = 1'b0;
  endtask

  // Counts remaining busy cycles from the current negedge, bounded.
  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'd0;
    srcA   = 32'd0;
    srcB   = 32'd0;
    cancel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // MULT -3 * 5 = -15; old hi/lo remain visible while busy
    do_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("mult_busy_rise", {31'd0, busy}, 32'd1);
    check("mult_old_hi", hi, 32'd0);
    wait_done("mult_cycles", 5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);

    do_op(3'd4, 32'd7, 32'd2, 1'b0);
    wait_done("divu_cycles", 10);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done("div_neg_cycles", 10);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("div_ovf_cycles", 10);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    // MTHI then divide by zero: full latency, HI/LO untouched
    do_op(3'd5, 32'h0000_1234, 32'd0, 1'b0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h0000_1234);
    do_op(3'd3, 32'd5, 32'd0, 1'b0);
    wait_done("div0_cycles", 10);
    check("div0_hi", hi, 32'h0000_1234);
    check("div0_lo", lo, 32'h8000_0000);

    // MULTU max*max, with MTLO and MULT issued while busy (both ignored)
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd6, 32'h0000_DEAD, 32'd0, 1'b0);
    do_op(3'd1, 32'd2, 32'd3, 1'b0);
    wait_done("multu_cycles_left", 3);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'd1);
    check("multu_idle_after", {31'd0, busy}, 32'd0);

    // Start on the final busy cycle is dropped
    do_op(3'd1, 32'd2, 32'd3, 1'b0);
    repeat (4) @(negedge clk);
    do_op(3'd6, 32'h0000_BEEF, 32'd0, 1'b0);
    check("final_cycle_busy", {31'd0, busy}, 32'd0);
    check("final_cycle_lo", lo, 32'd6);
    check("final_cycle_hi", hi, 32'd0);

    // Cancelled starts and no-op codes
    do_op(3'd1, 32'd7, 32'd9, 1'b1);
    check("cancel_mult_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("cancel_mult_busy2", {31'd0, busy}, 32'd0);
    do_op(3'd6, 32'h0000_0055, 32'd0, 1'b1);
    check("cancel_mtlo_lo", lo, 32'd6);
    do_op(3'd7, 32'd1, 32'd1, 1'b0);
    check("nop7_busy", {31'd0, busy}, 32'd0);
    check("nop7_hi", hi, 32'd0);

    // Reset during DIV busy cycle 3; no late commit afterwards
    do_op(3'd6, 32'h0000_0077, 32'd0, 1'b0);
    do_op(3'd3, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("rst_late_hi", hi, 32'd0);
    check("rst_late_lo", lo, 32'd0);
    check("rst_late_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
